// File: rtl/sr_latch_exerciser.sv
// sr_latch_exerciser: drives a NOR SR latch with non-overlapping S/R pulses, samples Q/Qn, counts errors.
// Defining SR_LATCH_EXERCISER_RETRY_EN adds one double-length re-drive before a mismatch is reported.
module sr_latch_exerciser #(
    parameter int PULSE_W     = 4,
    parameter int SETTLE_W    = 3,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    output logic             s_out,
    output logic             r_out,
    input  logic             q_in,
    input  logic             qn_in,
    output logic             result_valid,
    output logic             result_q,
    output logic             result_err,
    output logic             result_retry,
    output logic [CNT_W-1:0] err_count,
    output logic             busy
);
`ifdef SR_LATCH_EXERCISER_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif
    localparam int CW = $clog2(2 * PULSE_W + SETTLE_W + 1);

    typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, SAMPLE} state_t;

    state_t                 state, state_d;
    logic [CW-1:0]          cnt, cnt_d;
    logic [SYNC_STAGES-1:0] q_sync, qn_sync;
    logic                   qs, qns, accept, line, line_d, s_d, r_d;
    logic                   expected, hold_op, retried, redo;
    logic                   drive_end, settle_end, sample_now, bad, retry_go;

    assign qs         = q_sync[SYNC_STAGES-1];
    assign qns        = qn_sync[SYNC_STAGES-1];
    assign cmd_ready  = rst_n & ena & (state == IDLE);
    assign accept     = cmd_valid & cmd_ready;
    assign busy       = state != IDLE;
    assign drive_end  = cnt == CW'(retried ? 2 * PULSE_W - 1 : PULSE_W - 1);
    assign settle_end = cnt == CW'(SETTLE_W - 1);
    assign sample_now = (state == SETTLE) & settle_end;
    assign bad        = (qs != expected) | (qs == qns);
    assign retry_go   = RETRY_EN & bad & ~retried & ~hold_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt + 1'b1;
        case (state)
            IDLE: begin
                cnt_d = '0;
                if (accept) state_d = (cmd_op == 2'b00) ? SETTLE : DRIVE;
            end
            DRIVE: if (drive_end) begin
                state_d = SETTLE;
                cnt_d   = '0;
            end
            SETTLE: if (settle_end) begin
                state_d = SAMPLE;
                cnt_d   = '0;
            end
            SAMPLE: begin
                cnt_d   = '0;
                state_d = redo ? DRIVE : IDLE;
            end
        endcase
    end

    // line=1 selects S; s_out/r_out are registered from the next state so they never overlap or glitch
    always_comb begin
        line_d = accept ? (cmd_op == 2'b01) | ((cmd_op == 2'b11) & ~qs) : line;
        s_d    = (state_d == DRIVE) & line_d;
        r_d    = (state_d == DRIVE) & ~line_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_sync       <= '0;
            qn_sync      <= '0;
            s_out        <= 1'b0;
            r_out        <= 1'b0;
            line         <= 1'b0;
            expected     <= 1'b0;
            hold_op      <= 1'b0;
            retried      <= 1'b0;
            redo         <= 1'b0;
            result_valid <= 1'b0;
            result_q     <= 1'b0;
            result_err   <= 1'b0;
            result_retry <= 1'b0;
            err_count    <= '0;
        end else begin
            q_sync       <= {q_sync[SYNC_STAGES-2:0], q_in};
            qn_sync      <= {qn_sync[SYNC_STAGES-2:0], qn_in};
            s_out        <= s_d;
            r_out        <= r_d;
            line         <= line_d;
            result_valid <= 1'b0;
            if (accept) begin
                expected <= cmd_op[1] ? (cmd_op[0] ? ~qs : 1'b0) : (cmd_op[0] ? 1'b1 : qs);
                hold_op  <= cmd_op == 2'b00;
                retried  <= 1'b0;
            end
            if (sample_now) begin
                redo    <= retry_go;
                retried <= retried | retry_go;
                if (!retry_go) begin
                    result_valid <= 1'b1;
                    result_q     <= qs;
                    result_err   <= bad;
                    result_retry <= retried;
                    if (bad && !(&err_count)) err_count <= err_count + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_sr_latch_exerciser.sv
// tb_sr_latch_exerciser: directed test of sr_latch_exerciser against a behavioural NOR latch model.
// Build with SR_LATCH_EXERCISER_RETRY_EN defined to check the retry timing instead.
module tb_sr_latch_exerciser;
    logic       clk = 1'b0;
    logic       rst_n, ena, cmd_valid, cmd_ready;
    logic [1:0] cmd_op;
    logic       s_out, r_out, q_in, qn_in;
    logic       result_valid, result_q, result_err, result_retry, busy;
    logic [7:0] err_count;

    int checks = 0;
    int failures = 0;
    int overlap = 0;
    logic       lq = 1'b0;
    int         mode = 0;
    logic [63:0] sh, rh, vh;

    sr_latch_exerciser dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .s_out(s_out), .r_out(r_out), .q_in(q_in), .qn_in(qn_in),
        .result_valid(result_valid), .result_q(result_q), .result_err(result_err),
        .result_retry(result_retry), .err_count(err_count), .busy(busy)
    );

    always #5 clk = ~clk;

    // mode 0: healthy latch, 1: forbidden Q=Qn=0, 2: Q stuck at 0
    always @(s_out or r_out) begin
        if (s_out) lq = 1'b1;
        else if (r_out) lq = 1'b0;
    end
    assign q_in  = (mode == 0) ? lq : 1'b0;
    assign qn_in = (mode == 0) ? ~lq : (mode == 2);

    always @(negedge clk) if (s_out === 1'b1 && r_out === 1'b1) overlap++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op);
        @(negedge clk);
        cmd_op    = op;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // bit k of each history word = value seen in cycle k after the accept edge
    task automatic capture(input int first, input int last);
        if (first == 1) begin
            sh = '0;
            rh = '0;
            vh = '0;
        end
        for (int k = first; k <= last; k++) begin
            @(negedge clk);
            sh[k] = s_out;
            rh[k] = r_out;
            vh[k] = result_valid;
        end
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00;
        @(negedge clk);
        check("reset_outs", {cmd_ready, s_out, r_out, result_valid, result_q, result_err, result_retry, busy}, 8'h00);
        check("reset_cnt", err_count, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("ready_after_reset", cmd_ready, 1'b1);

        issue(2'b01);
        capture(1, 12);
        check("set_s", sh, 64'h1E);
        check("set_r", rh, 64'h0);
        check("set_valid", vh, 64'h100);
        check("set_q", result_q, 1'b1);
        check("set_err", result_err, 1'b0);
        check("set_cnt", err_count, 8'd0);
        check("set_retry", result_retry, 1'b0);

        issue(2'b11);
        capture(1, 12);
        check("tog1_r", rh, 64'h1E);
        check("tog1_s", sh, 64'h0);
        check("tog1_valid", vh, 64'h100);
        check("tog1_q", result_q, 1'b0);
        check("tog1_err", result_err, 1'b0);
        issue(2'b11);
        capture(1, 12);
        check("tog2_s", sh, 64'h1E);
        check("tog2_r", rh, 64'h0);
        check("tog2_q", result_q, 1'b1);

        mode = 1;
        repeat (3) @(negedge clk);
        issue(2'b00);
        capture(1, 8);
        check("forbid_valid", vh, 64'h10);
        check("forbid_drive", sh | rh, 64'h0);
        check("forbid_err", result_err, 1'b1);
        check("forbid_cnt", err_count, 8'd1);
        for (int i = 0; i < 300; i++) begin
            issue(2'b00);
            repeat (4) @(negedge clk);
        end
        check("sat_cnt", err_count, 8'hFF);
        check("sat_err", result_err, 1'b1);

        mode = 2;
        repeat (3) @(negedge clk);
        issue(2'b01);
        capture(1, 24);
`ifdef SR_LATCH_EXERCISER_RETRY_EN
        check("stuck_s", sh, 64'h1FE1E);
        check("stuck_valid", vh, 64'h100000);
        check("stuck_retry", result_retry, 1'b1);
`else
        check("stuck_s", sh, 64'h1E);
        check("stuck_valid", vh, 64'h100);
        check("stuck_retry", result_retry, 1'b0);
`endif
        check("stuck_err", result_err, 1'b1);
        check("stuck_q", result_q, 1'b0);
        check("stuck_cnt", err_count, 8'hFF);

        mode = 0;
        repeat (3) @(negedge clk);
        issue(2'b01);
        capture(1, 2);
        check("pre_reset_s", s_out, 1'b1);
        rst_n = 1'b0;
        #1 check("mid_reset_drive", {s_out, r_out, busy, result_valid}, 4'b0000);
        capture(1, 2);
        rst_n = 1'b1;
        capture(3, 12);
        check("reset_no_result", vh, 64'h0);
        check("reset_no_drive", sh | rh, 64'h0);
        check("reset_ready", cmd_ready, 1'b1);
        check("reset_cnt_clear", err_count, 8'd0);

        @(negedge clk);
        ena = 1'b0; cmd_valid = 1'b1; cmd_op = 2'b01;
        #1 check("ena_low_ready", cmd_ready, 1'b0);
        capture(1, 10);
        check("ena_low_pulses", sh | rh, 64'h0);
        check("ena_low_valid", vh, 64'h0);
        cmd_valid = 1'b0;
        ena = 1'b1;

        issue(2'b10);
        capture(1, 1);
        ena = 1'b0;
        capture(2, 12);
        check("drop_r", rh, 64'h1E);
        check("drop_s", sh, 64'h0);
        check("drop_valid", vh, 64'h100);
        check("drop_q", result_q, 1'b0);
        check("drop_err", result_err, 1'b0);
        check("drop_ready", cmd_ready, 1'b0);

        check("no_overlap", overlap, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
